// File: rtl/lbp_param_if.sv
// rtl/lbp_param_if.sv - control, gray-read and LBP-write signals of the LBP engine
interface lbp_param_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
);
    logic              start;
    logic [PIX_W-1:0]  thr;
    logic              border_zero;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic              gray_ready;
    logic [PIX_W-1:0]  gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              busy;
    logic              finish;

    modport master (
        output start, thr, border_zero, gray_ready, gray_data,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, busy, finish
    );

    modport slave (
        input  start, thr, border_zero, gray_ready, gray_data,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, busy, finish
    );
endinterface

// File: rtl/lbp_param.sv
// rtl/lbp_param.sv - 3x3 local binary pattern engine over a gray frame in external memory
module lbp_param #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
) (
    input  logic         clk,
    input  logic         reset,
    lbp_param_if.slave   bus
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_BORDER = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0]  ROW_PEN  = ROW_W'(IMG_H - 2);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]  COL_PEN  = COL_W'(IMG_W - 2);

    logic [2:0]        state;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] pix_addr;
    logic [3:0]        fetch_idx;
    logic [PIX_W-1:0]  center;
    logic [7:0]        code;
    logic [PIX_W-1:0]  thr_q;
    logic              bz_q;
    logic              lbp_valid_q;
    logic [ADDR_W-1:0] lbp_addr_q;
    logic [7:0]        lbp_data_q;
    logic              busy_q;
    logic              finish_q;

    logic [ADDR_W-1:0] fetch_addr;
    logic [PIX_W:0]    cmp_sum;
    logic              bit_set;
    logic [ROW_W-1:0]  n_row;
    logic [COL_W-1:0]  n_col;
    logic [ADDR_W-1:0] n_addr;
    logic              n_done;
    logic              n_border;

    // Neighbour addresses are offsets from a running pixel address, so no multiply is needed.
    always_comb begin
        fetch_addr = pix_addr;
        case (fetch_idx)
            4'd1:    fetch_addr = pix_addr - W_A - ONE_A;
            4'd2:    fetch_addr = pix_addr - W_A;
            4'd3:    fetch_addr = pix_addr - W_A + ONE_A;
            4'd4:    fetch_addr = pix_addr - ONE_A;
            4'd5:    fetch_addr = pix_addr + ONE_A;
            4'd6:    fetch_addr = pix_addr + W_A - ONE_A;
            4'd7:    fetch_addr = pix_addr + W_A;
            4'd8:    fetch_addr = pix_addr + W_A + ONE_A;
            default: fetch_addr = pix_addr;
        endcase
    end

    // Widened by one bit so center+thr saturating past full scale can never match.
    assign cmp_sum = {1'b0, center} + {1'b0, thr_q};
    assign bit_set = ({1'b0, bus.gray_data} >= cmp_sum);

    // Without border output the walk jumps from (r,W-2) straight to (r+1,1).
    always_comb begin
        n_row = row;
        n_col = col;
        n_addr = pix_addr + ONE_A;
        if (bz_q) begin
            n_done = (row == ROW_LAST) && (col == COL_LAST);
            if (col == COL_LAST) begin
                n_row = row + ROW_W'(1);
                n_col = '0;
            end else begin
                n_col = col + COL_W'(1);
            end
        end else begin
            n_done = (row == ROW_PEN) && (col == COL_PEN);
            if (col == COL_PEN) begin
                n_row  = row + ROW_W'(1);
                n_col  = COL_W'(1);
                n_addr = pix_addr + ADDR_W'(3);
            end else begin
                n_col = col + COL_W'(1);
            end
        end
        n_border = (n_row == '0) || (n_row == ROW_LAST) || (n_col == '0) || (n_col == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            row         <= '0;
            col         <= '0;
            pix_addr    <= '0;
            fetch_idx   <= '0;
            center      <= '0;
            code        <= '0;
            thr_q       <= '0;
            bz_q        <= 1'b0;
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            lbp_valid_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        thr_q     <= bus.thr;
                        bz_q      <= bus.border_zero;
                        busy_q    <= 1'b1;
                        finish_q  <= 1'b0;
                        fetch_idx <= '0;
                        if (bus.border_zero) begin
                            row         <= '0;
                            col         <= '0;
                            pix_addr    <= '0;
                            state       <= S_BORDER;
                            lbp_valid_q <= 1'b1;
                            lbp_addr_q  <= '0;
                            lbp_data_q  <= '0;
                        end else begin
                            row      <= ROW_W'(1);
                            col      <= COL_W'(1);
                            pix_addr <= W_A + ONE_A;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (bus.gray_ready) begin
                        if (fetch_idx == 4'd0) begin
                            center <= bus.gray_data;
                        end else begin
                            code <= {bit_set, code[7:1]};
                        end
                        if (fetch_idx == 4'd8) begin
                            fetch_idx   <= '0;
                            state       <= S_WRITE;
                            lbp_valid_q <= 1'b1;
                            lbp_addr_q  <= pix_addr;
                            lbp_data_q  <= {bit_set, code[7:1]};
                        end else begin
                            fetch_idx <= fetch_idx + 4'd1;
                        end
                    end
                end
                S_WRITE, S_BORDER: begin
                    if (n_done) begin
                        state    <= S_DONE;
                        busy_q   <= 1'b0;
                        finish_q <= 1'b1;
                    end else begin
                        row      <= n_row;
                        col      <= n_col;
                        pix_addr <= n_addr;
                        if (n_border) begin
                            state       <= S_BORDER;
                            lbp_valid_q <= 1'b1;
                            lbp_addr_q  <= n_addr;
                            lbp_data_q  <= '0;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.gray_req  = (state == S_FETCH);
    assign bus.gray_addr = (state == S_FETCH) ? fetch_addr : '0;
    assign bus.lbp_valid = lbp_valid_q;
    assign bus.lbp_addr  = lbp_addr_q;
    assign bus.lbp_data  = lbp_data_q;
    assign bus.busy      = busy_q;
    assign bus.finish    = finish_q;
endmodule

// File: tb/tb_lbp_param.sv
// tb/tb_lbp_param.sv - scoreboard bench for lbp_param on a 4x4 frame
module tb_lbp_param;
    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lbp_param_if #(.PIX_W(8), .ADDR_W(14)) bus();

    lbp_param #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [7:0]  mem [16];
    int          exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ready_pct = 100;
    logic        wait_prev = 1'b0;
    logic [13:0] addr_prev = '0;

    assign bus.gray_data = mem[bus.gray_addr[3:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_code(input int r, input int c, input int t);
        int dr[8];
        int dc[8];
        int ctr;
        logic [7:0] code;
        dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
        dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
        ctr = int'(mem[r*W + c]);
        code = '0;
        for (int k = 0; k < 8; k++)
            if (int'(mem[(r + dr[k])*W + c + dc[k]]) >= ctr + t) code[k] = 1'b1;
        return code;
    endfunction

    task automatic push_expected(input int t, input bit bz);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (r > 0 && r < H-1 && c > 0 && c < W-1)
                    exp_q.push_back(((r*W + c) << 8) | int'(model_code(r, c, t)));
                else if (bz)
                    exp_q.push_back((r*W + c) << 8);
            end
    endtask

    // Write scoreboard, wait-state address hold check, and random ready generation.
    always @(negedge clk) begin
        if (bus.lbp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_write_addr", 32'(bus.lbp_addr), 32'hFFFF_FFFF);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.lbp_addr), 32'(e >> 8));
                check("wr_data", 32'(bus.lbp_data), 32'(e & 8'hFF));
                check("wr_no_finish", 32'(bus.finish), 32'd0);
            end
        end
        if (wait_prev && bus.gray_req)
            check("addr_hold", 32'(bus.gray_addr), 32'(addr_prev));
        bus.gray_ready = (ready_pct >= 100) || (int'($urandom_range(99)) < ready_pct);
        wait_prev = bus.gray_req && !bus.gray_ready;
        addr_prev = bus.gray_addr;
    end

    task automatic run_frame(input string tag, input int t, input bit bz, input int pct,
                             input int exp_cyc, input int ign_at);
        int n;
        ready_pct = pct;
        push_expected(t, bz);
        @(negedge clk);
        bus.thr = t[7:0];
        bus.border_zero = bz;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.finish && n < 5000) begin
            if (n == ign_at) begin
                bus.start = 1'b1;
                bus.thr = 8'd77;
                bus.border_zero = ~bz;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        check({tag, "_finish"}, 32'(bus.finish), 32'd1);
        if (exp_cyc > 0) check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        @(negedge clk);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.thr = '0;
        bus.border_zero = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'd5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gray_req", 32'(bus.gray_req), 32'd0);
        check("rst_gray_addr", 32'(bus.gray_addr), 32'd0);
        check("rst_lbp_valid", 32'(bus.lbp_valid), 32'd0);
        check("rst_lbp_addr", 32'(bus.lbp_addr), 32'd0);
        check("rst_lbp_data", 32'(bus.lbp_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_finish", 32'(bus.finish), 32'd0);
        @(negedge clk) reset = 1'b0;

        run_frame("flat", 0, 1'b0, 100, 40, -1);
        repeat (3) @(negedge clk);
        check("finish_held", 32'(bus.finish), 32'd1);

        mem[5] = 8'd9;
        run_frame("peak", 0, 1'b0, 100, 40, -1);
        mem[5] = 8'd5;
        run_frame("thr1", 1, 1'b0, 100, 40, -1);

        for (int i = 0; i < 16; i++) mem[i] = 8'd255;
        run_frame("sat", 255, 1'b0, 100, 40, -1);
        run_frame("max_thr0", 0, 1'b0, 100, 40, -1);

        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(255));
        run_frame("bz_rand", 3, 1'b1, 100, 52, -1);
        run_frame("wait_rand", 3, 1'b0, 30, -1, -1);
        run_frame("wait_bz", 3, 1'b1, 30, -1, -1);
        run_frame("ign_start", 2, 1'b0, 100, 40, 15);

        // Abort mid-frame, then confirm a fresh frame still runs cleanly.
        ready_pct = 100;
        push_expected(0, 1'b0);
        @(negedge clk);
        bus.thr = '0;
        bus.border_zero = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (13) @(negedge clk);
        check("abort_in_fetch", 32'(bus.gray_req), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("abort_gray_req", 32'(bus.gray_req), 32'd0);
        check("abort_lbp_valid", 32'(bus.lbp_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_dominates_start", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idle_writes", 32'(exp_q.size()), 32'd0);
        run_frame("rerun", 0, 1'b0, 100, 40, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lbp_param.md
LBP_PARAM -- requirements
Module: lbp_param

Interface
REQ-001 SHALL have parameter IMG_W, default 128, image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 128, image height in pixels (>=3).
REQ-003 SHALL have parameter PIX_W, default 8, gray pixel width in bits.
REQ-004 SHALL have parameter ADDR_W, default 14, address width; 2^ADDR_W >= IMG_W*IMG_H.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse; begins a frame when idle or done.
REQ-008 SHALL have port thr  input  PIX_W  comparison offset, sampled on accepted start.
REQ-009 SHALL have port border_zero  input  1  1 = also write 0 to border pixels; sampled on start.
REQ-010 SHALL have port gray_req  output  1  read request.
REQ-011 SHALL have port gray_addr  output  ADDR_W  read address, row*IMG_W+col.
REQ-012 SHALL have port gray_ready  input  1  read accepted; gray_data valid same cycle.
REQ-013 SHALL have port gray_data  input  PIX_W  read data.
REQ-014 SHALL have port lbp_valid  output  1  one-cycle write strobe.
REQ-015 SHALL have port lbp_addr  output  ADDR_W  write address.
REQ-016 SHALL have port lbp_data  output  8  LBP code.
REQ-017 SHALL have port busy  output  1  high from accepted start until finish.
REQ-018 SHALL have port finish  output  1  frame complete; held until next start or reset.

Function
REQ-019 SHALL use states IDLE, FETCH, WRITE, BORDER, DONE; start accepted only in IDLE or DONE, ignored otherwise.
REQ-020 SHALL visit pixels in raster order, row 0..IMG_H-1, col 0..IMG_W-1.
REQ-021 SHALL, for interior pixels, fetch center then neighbours (r-1,c-1),(r-1,c),(r-1,c+1),(r,c-1),(r,c+1),(r+1,c-1),(r+1,c),(r+1,c+1) as bits 0..7.
REQ-022 SHALL treat a fetch as complete only in a cycle with gray_req=1 and gray_ready=1; gray_addr SHALL hold stable while gray_req=1 and gray_ready=0.
REQ-023 SHALL keep gray_req high continuously through all 9 fetches of a pixel and low in WRITE, BORDER, IDLE, DONE.
REQ-024 SHALL set bit k = 1 iff neighbour >= center + thr, evaluated in PIX_W+1 bits (no wrap; center+thr > max gives 0).
REQ-025 SHALL enter WRITE the cycle after the 9th fetch, assert lbp_valid for exactly one cycle with lbp_addr = pixel address, lbp_data = code.
REQ-026 SHALL, when border_zero=1, emit each border pixel in BORDER state: one lbp_valid cycle, lbp_data=0, no gray fetch.
REQ-027 SHALL, when border_zero=0, skip border pixels with zero cycles spent.
REQ-028 SHALL, after the last written pixel ((IMG_H-2,IMG_W-2) or (IMG_H-1,IMG_W-1)), go to DONE: finish=1, busy=0.
REQ-029 SHALL produce no lbp_valid pulse with finish=1 in the same cycle.
REQ-030 SHALL compute addresses with row/col counters only (no division); col wrap at IMG_W-1 SHALL advance row.
REQ-031 SHALL make interior latency = 9 accepted fetches + 1 WRITE cycle; zero-wait throughput 10 cycles/pixel.

Reset
REQ-032 SHALL, on reset high at a clock edge, enter IDLE and drive gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, busy=0, finish=0.
REQ-033 SHALL abort any in-progress frame on reset with no further fetch or write; reset dominates a simultaneous start.

Verification
REQ-034 IMG_W=IMG_H=4, thr=0, border_zero=0, ready always 1, image all 5 -> 4 writes addr 5,6,9,10 data 0xFF, finish after 40 cycles.
REQ-035 Same image, pixel 5 = 9, thr=0 -> write addr 5 data 0x00; addr 6 data 0xF7? no: addr 6 bit3 neighbour 9>=5 set, data 0xFF.
REQ-036 thr=1, all pixels 5 -> all interior data 0x00; thr=255, PIX_W=8, pixel 255 -> 0x00 (no wrap).
REQ-037 border_zero=1, 4x4 -> 16 writes addr 0..15 in order, border data 0x00, interior codes per REQ-024.
REQ-038 gray_ready random 30% high -> gray_addr stable under wait, codes identical to zero-wait run.
REQ-039 reset asserted mid-FETCH -> next cycle gray_req=0, lbp_valid=0, busy=0; new start reruns frame correctly.
